// File: rtl/axi_arb_pkg.sv
// Shared types, constants and helpers for the AXI AW round-robin arbiter.
package axi_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int STAT_W = 32;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/axi_arb_route_fifo.sv
// In-order route FIFO recording which requester owns the next W burst.
// Pointers carry one extra wrap bit so full/empty/count fall out of plain subtraction.
module axi_arb_route_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign count_o = r_wr_ptr - r_rd_ptr;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; empty_o masks stale entries, and a reset-free array maps onto plain RAM/regs.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din_i;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_pop_on_empty: assert (!(pop_i && empty_o));
    end
  end
`endif

endmodule

// File: rtl/axi_aw_rr_arbiter.sv
// Round-robin AW arbiter for one crossbar master port; registers the winner and logs W routing order.
// Optional per-requester grant counters: define AXI_ARB_STATS_EN.
module axi_aw_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NB_REQ         = 2,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AW_PL_WIDTH    = AXI_ADDR_WIDTH + 29,
  parameter int ROUTE_DEPTH    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NB_REQ-1:0]                         req_valid_i,
  output logic [NB_REQ-1:0]                         req_ready_o,
  input  logic [NB_REQ-1:0][AXI_ID_WIDTH-1:0]       req_id_i,
  input  logic [NB_REQ-1:0][AW_PL_WIDTH-1:0]        req_pl_i,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [AXI_ID_WIDTH+idx_w(NB_REQ)-1:0]     out_id_o,
  output logic [AW_PL_WIDTH-1:0]                    out_pl_o,
  output logic                                      wsel_valid_o,
  output logic [idx_w(NB_REQ)-1:0]                  wsel_o,
  input  logic                                      wsel_pop_i
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [NB_REQ-1:0][STAT_W-1:0]             grant_cnt_o
`endif
);

  localparam int                IDX_W    = idx_w(NB_REQ);
  localparam int                OUT_ID_W = AXI_ID_WIDTH + IDX_W;
  localparam int                CNT_W    = $clog2(ROUTE_DEPTH) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB_REQ - 1);

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       w_win;
  logic                   w_grant;
  logic [OUT_ID_W-1:0]    r_id;
  logic [AW_PL_WIDTH-1:0] r_pl;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CNT_W-1:0]       w_fifo_count;
  logic [IDX_W-1:0]       w_fifo_head;

  // First valid requester at or after ptr, wrapping; scanning downward leaves the lowest match.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NB_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]  ptr);
    logic [IDX_W-1:0] hi_pick;
    logic [IDX_W-1:0] any_pick;
    logic             hi_found;
    hi_pick  = '0;
    any_pick = '0;
    hi_found = 1'b0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        any_pick = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hi_pick  = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi_pick : any_pick;
  endfunction

  assign w_win = rr_pick(req_valid_i, r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Full check looks at the count before any same-cycle pop, trading one cycle for a shorter path.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && (|req_valid_i) && !w_fifo_full) begin
          w_grant     = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_pl  <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_win == LAST_IDX) ? '0 : w_win + IDX_W'(1);
      r_id  <= {w_win, req_id_i[w_win]};
      r_pl  <= req_pl_i[w_win];
    end
  end

  assign req_ready_o  = w_grant ? ({{(NB_REQ-1){1'b0}}, 1'b1} << w_win) : '0;
  assign out_valid_o  = (r_state == HOLD);
  assign out_id_o     = r_id;
  assign out_pl_o     = r_pl;
  assign wsel_valid_o = !w_fifo_empty;
  assign wsel_o       = w_fifo_head;

  // Pushed at grant rather than at the master handshake so early W beats can already be routed.
  axi_arb_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .WIDTH (IDX_W)
  ) u_route_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_grant),
    .din_i   (w_win),
    .pop_i   (wsel_pop_i),
    .dout_o  (w_fifo_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

`ifdef AXI_ARB_STATS_EN
  logic [NB_REQ-1:0][STAT_W-1:0] r_grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NB_REQ; i++) begin
        if (w_grant && (w_win == IDX_W'(i)) && (r_grant_cnt[i] != '1)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + STAT_W'(1);
        end
      end
    end
  end

  assign grant_cnt_o = r_grant_cnt;
`endif

`ifndef SYNTHESIS
  logic [NB_REQ-1:0]      r_chk_pend;
  logic                   r_chk_hold;
  logic [OUT_ID_W-1:0]    r_chk_id;
  logic [AW_PL_WIDTH-1:0] r_chk_pl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_pend <= '0;
      r_chk_hold <= 1'b0;
      r_chk_id   <= '0;
      r_chk_pl   <= '0;
    end else begin
      a_req_valid_stable: assert ((r_chk_pend & ~req_valid_i) == '0);
      a_out_stable:       assert (!r_chk_hold || ((out_id_o == r_chk_id) && (out_pl_o == r_chk_pl)));
      a_count_range:      assert (w_fifo_count <= CNT_W'(ROUTE_DEPTH));
      r_chk_pend <= req_valid_i & ~req_ready_o;
      r_chk_hold <= out_valid_o & ~out_ready_i;
      r_chk_id   <= out_id_o;
      r_chk_pl   <= out_pl_o;
    end
  end
`endif

endmodule

// File: tb/tb_axi_aw_rr_arbiter.sv
// Self-checking bench for axi_aw_rr_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_axi_aw_rr_arbiter;

  localparam int NB_REQ   = 2;
  localparam int ADDR_W   = 64;
  localparam int ID_W     = 4;
  localparam int PL_W     = ADDR_W + 29;
  localparam int DEPTH    = 4;
  localparam int IDX_W    = 1;
  localparam int OUT_ID_W = ID_W + IDX_W;

  logic                             clk;
  logic                             rst_n;
  logic [NB_REQ-1:0]                req_valid_i;
  logic [NB_REQ-1:0]                req_ready_o;
  logic [NB_REQ-1:0][ID_W-1:0]      req_id_i;
  logic [NB_REQ-1:0][PL_W-1:0]      req_pl_i;
  logic                             out_valid_o;
  logic                             out_ready_i;
  logic [OUT_ID_W-1:0]              out_id_o;
  logic [PL_W-1:0]                  out_pl_o;
  logic                             wsel_valid_o;
  logic [IDX_W-1:0]                 wsel_o;
  logic                             wsel_pop_i;
`ifdef AXI_ARB_STATS_EN
  logic [NB_REQ-1:0][31:0]          grant_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pending route queue, held AW, next-priority requester.
  int                  m_q[$];
  bit                  m_hold;
  int                  m_ptr;
  logic [OUT_ID_W-1:0] m_id;
  logic [PL_W-1:0]     m_pl;

  axi_aw_rr_arbiter #(
    .NB_REQ         (NB_REQ),
    .AXI_ADDR_WIDTH (ADDR_W),
    .AXI_ID_WIDTH   (ID_W),
    .AW_PL_WIDTH    (PL_W),
    .ROUTE_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_id_i     (req_id_i),
    .req_pl_i     (req_pl_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_id_o     (out_id_o),
    .out_pl_o     (out_pl_o),
    .wsel_valid_o (wsel_valid_o),
    .wsel_o       (wsel_o),
    .wsel_pop_i   (wsel_pop_i)
`ifdef AXI_ARB_STATS_EN
    ,
    .grant_cnt_o  (grant_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PL_W-1:0] rand_pl();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[PL_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid_i = '0;
    req_id_i    = '0;
    req_pl_i    = '0;
    out_ready_i = 1'b0;
    wsel_pop_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Returns the first non-zero req_ready_o seen within budget cycles, or zero on timeout.
  task automatic wait_grant(input int budget, output logic [NB_REQ-1:0] rdy);
    rdy = '0;
    for (int c = 0; c < budget; c++) begin
      if (req_ready_o !== '0) begin
        rdy = req_ready_o;
        break;
      end
      step();
    end
  endtask

  function automatic int model_winner();
    if (m_hold || m_q.size() >= DEPTH) return -1;
    for (int k = 0; k < NB_REQ; k++) begin
      int r;
      r = (m_ptr + k) % NB_REQ;
      if (req_valid_i[r]) return r;
    end
    return -1;
  endfunction

  task automatic model_edge(input int win, input bit pop);
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if (win >= 0) begin
      m_q.push_back(win);
      m_hold = 1'b1;
      m_id   = {IDX_W'(win), req_id_i[win]};
      m_pl   = req_pl_i[win];
      m_ptr  = (win + 1) % NB_REQ;
    end else if (m_hold && out_ready_i) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req_valid_i = 2'b11;
    req_id_i    = '0;
    req_pl_i    = '0;
    out_ready_i = 1'b1;
    wsel_pop_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready_o !== '0 || out_valid_o !== 1'b0 || wsel_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready=%b valid=%b wsel_valid=%b expected 00 0 0",
               req_ready_o, out_valid_o, wsel_valid_o);
    end
    n_cmp++;
    if (out_id_o !== '0 || out_pl_o !== '0 || wsel_o !== '0) begin
      n_bad++;
      $display("FAIL reset_data: id=%h pl=%h wsel=%h expected all 0", out_id_o, out_pl_o, wsel_o);
    end
`ifdef AXI_ARB_STATS_EN
    n_cmp++;
    if (grant_cnt_o !== '0) begin
      n_bad++;
      $display("FAIL reset_stats: cnt=%h expected 0", grant_cnt_o);
    end
`endif
    req_valid_i = '0;
    rst_n       = 1'b1;
  endtask

  task automatic test_alternate();
    logic [NB_REQ-1:0]   rdy;
    logic [NB_REQ-1:0]   exp_rdy;
    logic [OUT_ID_W-1:0] exp_id;
    do_reset();
    req_id_i[0] = 4'h3;
    req_id_i[1] = 4'hA;
    req_pl_i[0] = rand_pl();
    req_pl_i[1] = rand_pl();
    out_ready_i = 1'b1;
    req_valid_i = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(6, rdy);
      exp_rdy = (g % 2 == 1) ? 2'b10 : 2'b01;
      n_cmp++;
      if (rdy !== exp_rdy) begin
        n_bad++;
        $display("FAIL alt_grant[%0d]: ready=%b expected %b", g, rdy, exp_rdy);
      end
      step();
      exp_id = {IDX_W'(g % 2), (g % 2 == 1) ? 4'hA : 4'h3};
      n_cmp++;
      if (out_valid_o !== 1'b1 || out_id_o !== exp_id || req_ready_o !== '0) begin
        n_bad++;
        $display("FAIL alt_out[%0d]: valid=%b id=%h ready=%b expected 1 %h 00",
                 g, out_valid_o, out_id_o, req_ready_o, exp_id);
      end
      step();
    end
  endtask

  task automatic test_single_req1();
    logic [NB_REQ-1:0] rdy;
    logic [PL_W-1:0]   pl1;
    do_reset();
    out_ready_i = 1'b1;
    pl1         = rand_pl();
    req_id_i[1] = 4'h5;
    req_pl_i[1] = pl1;
    req_valid_i = 2'b10;
    #1;
    wait_grant(4, rdy);
    n_cmp++;
    if (rdy !== 2'b10) begin
      n_bad++;
      $display("FAIL single_grant: ready=%b expected 10", rdy);
    end
    step();
    req_valid_i = '0;
    n_cmp++;
    if (out_valid_o !== 1'b1 || out_id_o !== 5'h15 || out_pl_o !== pl1) begin
      n_bad++;
      $display("FAIL single_out: valid=%b id=%h pl=%h expected 1 15 %h", out_valid_o, out_id_o, out_pl_o, pl1);
    end
    step();
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_release: valid=%b expected 0", out_valid_o);
    end
  endtask

  task automatic test_hold_stall();
    logic [NB_REQ-1:0]   rdy;
    logic [PL_W-1:0]     pl0;
    logic [OUT_ID_W-1:0] exp_id;
    do_reset();
    pl0         = rand_pl();
    req_id_i[0] = 4'h7;
    req_id_i[1] = 4'h9;
    req_pl_i[0] = pl0;
    req_pl_i[1] = rand_pl();
    req_valid_i = 2'b11;
    #1;
    wait_grant(4, rdy);
    n_cmp++;
    if (rdy !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_grant: ready=%b expected 01", rdy);
    end
    step();
    req_id_i[0] = 4'hE;
    req_pl_i[0] = rand_pl();
    exp_id      = {1'b0, 4'h7};
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (out_valid_o !== 1'b1 || out_id_o !== exp_id || out_pl_o !== pl0 || req_ready_o !== '0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: valid=%b id=%h ready=%b expected 1 %h 00",
                 c, out_valid_o, out_id_o, req_ready_o, exp_id);
      end
      step();
    end
    out_ready_i = 1'b1;
    step();
    wait_grant(4, rdy);
    n_cmp++;
    if (rdy !== 2'b10) begin
      n_bad++;
      $display("FAIL stall_next_grant: ready=%b expected 10", rdy);
    end
  endtask

  task automatic test_fifo_full();
    int                grants;
    bit                got1;
    bit                drop1;
    int                exp_order[5];
    exp_order = '{1, 0, 1, 0, 1};
    do_reset();
    out_ready_i = 1'b1;
    req_id_i[0] = 4'h1;
    req_id_i[1] = 4'h2;
    req_valid_i = 2'b11;
    #1;
    grants = 0;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      if (req_ready_o !== '0) grants++;
      step();
    end
    n_cmp++;
    if (grants != 4) begin
      n_bad++;
      $display("FAIL full_fill: grants=%0d expected 4", grants);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      n_cmp++;
      if (req_ready_o !== '0 || wsel_valid_o !== 1'b1 || wsel_o !== 1'b0) begin
        n_bad++;
        $display("FAIL full_stall[%0d]: ready=%b wsel_valid=%b wsel=%b expected 00 1 0",
                 c, req_ready_o, wsel_valid_o, wsel_o);
      end
    end
    wsel_pop_i = 1'b1;
    #1;
    n_cmp++;
    if (req_ready_o !== '0) begin
      n_bad++;
      $display("FAIL full_pop_same_cycle: ready=%b expected 00", req_ready_o);
    end
    step();
    wsel_pop_i = 1'b0;
    #1;
    n_cmp++;
    if (req_ready_o !== 2'b01 || wsel_o !== 1'b1) begin
      n_bad++;
      $display("FAIL full_regrant: ready=%b wsel=%b expected 01 1", req_ready_o, wsel_o);
    end
    step();
    req_valid_i[0] = 1'b0;
    got1  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (wsel_valid_o !== 1'b1 || wsel_o !== IDX_W'(exp_order[k])) begin
        n_bad++;
        $display("FAIL fifo_order[%0d]: wsel_valid=%b wsel=%b expected 1 %0d",
                 k, wsel_valid_o, wsel_o, exp_order[k]);
      end
      drop1 = req_ready_o[1];
      if (drop1) got1 = 1'b1;
      wsel_pop_i = 1'b1;
      step();
      if (drop1) req_valid_i[1] = 1'b0;
    end
    wsel_pop_i = 1'b0;
    n_cmp++;
    if (got1 !== 1'b1) begin
      n_bad++;
      $display("FAIL fifo_drain_grant: req1 granted=%b expected 1", got1);
    end
    n_cmp++;
    if (wsel_valid_o !== 1'b0 || wsel_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fifo_empty: wsel_valid=%b wsel=%b expected 0 0", wsel_valid_o, wsel_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [NB_REQ-1:0] rdy;
    do_reset();
    out_ready_i = 1'b1;
    req_id_i[1] = 4'h2;
    req_valid_i = 2'b10;
    #1;
    wait_grant(4, rdy);
    n_cmp++;
    if (rdy !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_grant1: ready=%b expected 10", rdy);
    end
    step();
    req_id_i[0] = 4'h6;
    req_valid_i = 2'b01;
    step();
    wait_grant(4, rdy);
    n_cmp++;
    if (rdy !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_grant0: ready=%b expected 01", rdy);
    end
    out_ready_i = 1'b0;
    step();
    req_valid_i = '0;
    n_cmp++;
    if (out_valid_o !== 1'b1 || wsel_valid_o !== 1'b1 || wsel_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_hold: valid=%b wsel_valid=%b wsel=%b expected 1 1 1",
               out_valid_o, wsel_valid_o, wsel_o);
    end
`ifdef AXI_ARB_STATS_EN
    n_cmp++;
    if (grant_cnt_o[0] !== 32'd1 || grant_cnt_o[1] !== 32'd1) begin
      n_bad++;
      $display("FAIL mid_stats: cnt0=%0d cnt1=%0d expected 1 1", grant_cnt_o[0], grant_cnt_o[1]);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b0 || out_id_o !== '0 || out_pl_o !== '0 ||
        wsel_valid_o !== 1'b0 || wsel_o !== '0 || req_ready_o !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outs: valid=%b id=%h wsel_valid=%b wsel=%b ready=%b expected all 0",
               out_valid_o, out_id_o, wsel_valid_o, wsel_o, req_ready_o);
    end
`ifdef AXI_ARB_STATS_EN
    n_cmp++;
    if (grant_cnt_o !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_stats: cnt=%h expected 0", grant_cnt_o);
    end
`endif
    step();
    step();
    rst_n       = 1'b1;
    req_valid_i = 2'b11;
    #1;
    n_cmp++;
    if (req_ready_o !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_ptr_reset: ready=%b expected 01", req_ready_o);
    end
  endtask

  task automatic test_random();
    logic [NB_REQ-1:0] seen_rdy;
    logic [NB_REQ-1:0] exp_rdy;
    logic [IDX_W-1:0]  exp_wsel;
    int                win;
    do_reset();
    m_q.delete();
    m_hold   = 1'b0;
    m_ptr    = 0;
    m_id     = '0;
    m_pl     = '0;
    seen_rdy = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < NB_REQ; i++) begin
        if (req_valid_i[i] && seen_rdy[i]) begin
          req_valid_i[i] = ($urandom_range(0, 1) == 1);
          req_id_i[i]    = ID_W'($urandom());
          req_pl_i[i]    = rand_pl();
        end else if (!req_valid_i[i] && $urandom_range(0, 2) == 0) begin
          req_valid_i[i] = 1'b1;
          req_id_i[i]    = ID_W'($urandom());
          req_pl_i[i]    = rand_pl();
        end
      end
      out_ready_i = ($urandom_range(0, 9) < 6);
      wsel_pop_i  = (m_q.size() > 0) && (wsel_valid_o === 1'b1) && ($urandom_range(0, 1) == 1);
      #1;
      win     = model_winner();
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      n_cmp++;
      if (req_ready_o !== exp_rdy) begin
        n_bad++;
        $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, req_ready_o, exp_rdy);
      end
      n_cmp++;
      if (out_valid_o !== m_hold) begin
        n_bad++;
        $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, out_valid_o, m_hold);
      end
      if (m_hold) begin
        n_cmp++;
        if (out_id_o !== m_id || out_pl_o !== m_pl) begin
          n_bad++;
          $display("FAIL rnd_payload@%0d: id=%h pl=%h expected %h %h", cyc, out_id_o, out_pl_o, m_id, m_pl);
        end
      end
      exp_wsel = (m_q.size() > 0) ? IDX_W'(m_q[0]) : '0;
      n_cmp++;
      if (wsel_valid_o !== (m_q.size() > 0) || wsel_o !== exp_wsel) begin
        n_bad++;
        $display("FAIL rnd_wsel@%0d: valid=%b sel=%b expected %b %b",
                 cyc, wsel_valid_o, wsel_o, (m_q.size() > 0), exp_wsel);
      end
      seen_rdy = req_ready_o;
      model_edge(win, wsel_pop_i);
      step();
    end
    wsel_pop_i  = 1'b0;
    req_valid_i = req_valid_i & ~seen_rdy;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid_i = '0;
    req_id_i    = '0;
    req_pl_i    = '0;
    out_ready_i = 1'b0;
    wsel_pop_i  = 1'b0;
    test_reset();
    test_alternate();
    test_single_req1();
    test_hold_stall();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
